// File: rtl/fir_coef_bank_ctrl_if.sv
// Host-side configuration bus for the FIR coefficient bank controller.
// Carries the tap-write valid/ready handshake and the commit request/status.
interface fir_coef_bank_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_tap;
    logic [15:0] wr_data;
    logic        commit;
    logic [1:0]  commit_band;
    logic        pending;

    modport master (
        output wr_valid,
        output wr_tap,
        output wr_data,
        output commit,
        output commit_band,
        input  wr_ready,
        input  pending
    );

    modport slave (
        input  wr_valid,
        input  wr_tap,
        input  wr_data,
        input  commit,
        input  commit_band,
        output wr_ready,
        output pending
    );
endinterface

// File: rtl/fir_coef_bank_ctrl.sv
// Coefficient configuration controller for the 4-band FIR array.
// A host fills a single shadow coefficient set tap by tap; a commit then
// publishes the whole shadow set into one band's active set on a single
// sample-boundary edge, so no filter ever sees a half-updated set.
module fir_coef_bank_ctrl #(
    parameter int ORDER = 30
) (
    input  logic                  clk_slow,
    input  logic                  rst,
    input  logic                  sample_tick,
    fir_coef_bank_ctrl_if.slave   bus,
    input  logic                  err_clr,
    output logic                  update_done,
    output logic [1:0]            update_band,
    output logic                  err_tap,
    output logic                  err_commit,
    output logic [ORDER*16-1:0]   coef_b0,
    output logic [ORDER*16-1:0]   coef_b1,
    output logic [ORDER*16-1:0]   coef_b2,
    output logic [ORDER*16-1:0]   coef_b3
);

    localparam int NBANDS = 4;
    localparam logic [5:0] ORDER_W = 6'(ORDER);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic                pending_int;
    logic                wr_fire;
    logic                tap_ok;
    logic                apply;
    logic                commit_ok;
    logic                commit_err;
    logic [15:0]         wr_value;
    logic [1:0]          target_band;
    logic [ORDER*16-1:0] shadow;
    logic [ORDER*16-1:0] active [NBANDS];

    // Handshake and event decode shared by the datapath and error flags
    always_comb begin
        wr_fire    = bus.wr_valid && !pending_int;
        tap_ok     = {1'b0, bus.wr_tap} < ORDER_W;
        apply      = pending_int && sample_tick;
        commit_ok  = bus.commit && !pending_int;
        commit_err = bus.commit && pending_int;
        wr_value   = (bus.wr_data == 16'h8000) ? 16'h0000 : bus.wr_data;
    end

    // State register: IDLE means no commit outstanding, ARMED means waiting for a tick
    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: arm on an accepted commit, disarm on the sample tick that applies it
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.commit) state_next = ARMED;
            ARMED:   if (sample_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs of the FSM: writes stall while a commit is outstanding
    always_comb begin
        pending_int  = (state == ARMED);
        bus.pending  = pending_int;
        bus.wr_ready = !pending_int;
    end

    // Shadow set: one tap per accepted in-range write, negative zero folded to zero
    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (wr_fire && tap_ok) begin
            for (int i = 0; i < ORDER; i++) begin
                if (bus.wr_tap == 5'(i)) shadow[16*i +: 16] <= wr_value;
            end
        end
    end

    // Target band is captured only by a commit that actually arms the controller
    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            target_band <= 2'd0;
        end else if (commit_ok) begin
            target_band <= bus.commit_band;
        end
    end

    // Active sets: the whole shadow lands in the target band on one edge
    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBANDS; b++) active[b] <= '0;
        end else if (apply) begin
            active[target_band] <= shadow;
        end
    end

    // Update notification: one-cycle pulse, band index held between applies
    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            update_done <= 1'b0;
            update_band <= 2'd0;
        end else begin
            update_done <= apply;
            if (apply) update_band <= target_band;
        end
    end

    // Sticky error flags: a new error event takes priority over a clear
    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            err_tap    <= 1'b0;
            err_commit <= 1'b0;
        end else begin
            if (wr_fire && !tap_ok) err_tap <= 1'b1;
            else if (err_clr)       err_tap <= 1'b0;
            if (commit_err)         err_commit <= 1'b1;
            else if (err_clr)       err_commit <= 1'b0;
        end
    end

    assign coef_b0 = active[0];
    assign coef_b1 = active[1];
    assign coef_b2 = active[2];
    assign coef_b3 = active[3];

endmodule
